piso_tx: RTL and testbench

Parallel-in serial-out transmitter: the producer side of the single-bit serial links built from our shift-register chains. It accepts a WIDTH-bit word over a valid/ready handshake and drives it onto `serial_out` one bit per clock, with a `frame` strobe marking the active bits. It sits between a parallel source and a serial-in shift chain or serial receiver, and supports gap-free back-to-back words.

---
 rtl/piso_tx.sv | 124 ++++++++++++
 tb/tb_piso_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word intake, one bit per clock on serial_out.
// Optional even-parity trailer bit when PISO_TX_PARITY_EN is defined.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic              ser_q, ser_d;
    logic              frm_q, frm_d;
`ifdef PISO_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              last_cyc;
    logic              hs;
    logic              first_bit;
    logic              next_bit;
    logic [WIDTH-1:0]  sh_adv;

    // sh_q keeps the bit currently on serial_out at its outgoing end.
    assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign next_bit  = MSB_FIRST ? sh_q[WIDTH-2] : sh_q[1];
    assign sh_adv    = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

`ifdef PISO_TX_PARITY_EN
    assign last_cyc = (state_q == PARITY);
`else
    assign last_cyc = (state_q == SHIFT) && (cnt_q == LAST);
`endif

    assign din_ready  = rst & ((state_q == IDLE) | last_cyc);
    assign hs         = din_valid & din_ready;
    assign busy       = (state_q != IDLE);
    assign serial_out = ser_q;
    assign frame      = frm_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ser_d   = 1'b0;
        frm_d   = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (hs) begin
            // A new word may start straight out of the final cycle of the previous one.
            state_d = SHIFT;
            cnt_d   = '0;
            sh_d    = din;
            ser_d   = first_bit;
            frm_d   = 1'b1;
`ifdef PISO_TX_PARITY_EN
            par_d   = ^din;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
                        state_d = PARITY;
                        ser_d   = par_q;
                        frm_d   = 1'b1;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        sh_d  = sh_adv;
                        ser_d = next_bit;
                        frm_d = 1'b1;
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY:  state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            ser_q   <= 1'b0;
            frm_q   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ser_q   <= ser_d;
            frm_q   <= frm_d;
`ifdef PISO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an MSB-first and an LSB-first instance share stimulus and are checked
// against a queue-based bit-stream model, a directed table, and multi-cycle sequences.
module tb_piso_tx;
    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = W + (PAR ? 1 : 0);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         rdy_m, ser_m, frm_m, busy_m;
    logic         rdy_l, ser_l, frm_l, busy_l;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .serial_out(ser_m), .frame(frm_m), .busy(busy_m)
    );
    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .serial_out(ser_l), .frame(frm_l), .busy(busy_l)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: bits still to be sent after the one currently shown.
    logic mq_m[$];
    logic mq_l[$];
    logic m_ser_m = 1'b0, m_ser_l = 1'b0, m_frm = 1'b0;
    logic last_hs = 1'b0;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         sm;
        logic         sl;
        logic         fr;
        logic         rdy;
    } row_t;
    row_t tbl[$];

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_m.delete();
        mq_l.delete();
        m_ser_m = 1'b0;
        m_ser_l = 1'b0;
        m_frm   = 1'b0;
        last_hs = 1'b0;
    endtask

    task automatic check_model();
        logic m_rdy;
        m_rdy = rst && (mq_m.size() == 0);
        chk("ser_msb", ser_m, m_ser_m);
        chk("ser_lsb", ser_l, m_ser_l);
        chk("frame_msb", frm_m, m_frm);
        chk("frame_lsb", frm_l, m_frm);
        chk("busy_msb", busy_m, m_frm);
        chk("busy_lsb", busy_l, m_frm);
        chk("ready_msb", rdy_m, m_rdy);
        chk("ready_lsb", rdy_l, m_rdy);
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else begin
            last_hs = din_valid && (mq_m.size() == 0);
            if (last_hs) begin
                for (int k = W - 1; k >= 0; k--) mq_m.push_back(din[k]);
                for (int k = 0; k < W; k++) mq_l.push_back(din[k]);
                if (PAR) begin
                    mq_m.push_back(^din);
                    mq_l.push_back(^din);
                end
            end
            if (mq_m.size() > 0) begin
                m_ser_m = mq_m.pop_front();
                m_ser_l = mq_l.pop_front();
                m_frm   = 1'b1;
            end else begin
                m_ser_m = 1'b0;
                m_ser_l = 1'b0;
                m_frm   = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        din       = d;
        din_valid = v;
        #1;
        check_model();
        model_step();
    endtask

    task automatic add_word(input logic [W-1:0] w);
        tbl.push_back('{v: 1'b1, d: w, sm: 1'b0, sl: 1'b0, fr: 1'b0, rdy: 1'b1});
        for (int k = 0; k < W; k++)
            tbl.push_back('{v: 1'b0, d: '0, sm: w[W-1-k], sl: w[k], fr: 1'b1,
                            rdy: (k == W - 1) && !PAR});
        if (PAR)
            tbl.push_back('{v: 1'b0, d: '0, sm: ^w, sl: ^w, fr: 1'b1, rdy: 1'b1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        int best;
        bit done;

        add_word(8'hA5);
        add_word(8'h01);
        add_word(8'h07);
        add_word(8'h03);
        tbl.push_back('{v: 1'b0, d: '0, sm: 1'b0, sl: 1'b0, fr: 1'b0, rdy: 1'b1});

        // Power-on reset held for two cycles.
        model_reset();
        drive(1'b0, '0);
        drive(1'b0, '0);
        rst = 1'b1;
        drive(1'b0, '0);

        // Directed table.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d);
            chk("tbl_ser_msb", ser_m, tbl[i].sm);
            chk("tbl_ser_lsb", ser_l, tbl[i].sl);
            chk("tbl_frame", frm_m, tbl[i].fr);
            chk("tbl_ready", rdy_m, tbl[i].rdy);
        end

        // Back-to-back: FF, then 00 offered from the first bit on and held until taken.
        run = 0;
        best = 0;
        done = 1'b0;
        drive(1'b1, 8'hFF);
        for (int i = 0; i < 3 * FL && !done; i++) begin
            drive(1'b1, 8'h00);
            run = frm_m ? run + 1 : 0;
            if (run > best) best = run;
            done = last_hs;
        end
        chk_int("b2b_accept", int'(done), 1);
        for (int i = 0; i < FL + 3; i++) begin
            drive(1'b0, 8'h5A);
            run = frm_m ? run + 1 : 0;
            if (run > best) best = run;
        end
        chk_int("b2b_frame_run", best, 2 * FL);

        // Reset asserted while bit 3 of A5 is on the line.
        drive(1'b1, 8'hA5);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_ser", ser_m, 1'b0);
        chk("rst_mid_frame", frm_m, 1'b0);
        check_model();
        drive(1'b0, '0);
        drive(1'b0, '0);
        rst = 1'b1;
        drive(1'b1, 8'hA5);
        for (int i = 0; i < FL + 2; i++) drive(1'b0, 8'h00);

        // Randomized traffic; din changes every cycle, including mid-frame.
        for (int i = 0; i < 500; i++)
            drive(($urandom % 4) != 0, W'($urandom));
        for (int i = 0; i < FL + 2; i++) drive(1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
